// File: rtl/rgb_pwm_driver.sv
// rgb_pwm_driver: double-buffered three-channel PWM driving active-low RGB LED pads.
// Build option PWM_PHASE_STAGGER_EN offsets green/blue phases by 1/3 and 2/3 of a period.
module rgb_pwm_driver #(
    parameter int PWM_INTERVAL = 1200,
    localparam int W = $clog2(PWM_INTERVAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] duty_r,
    input  logic [W-1:0] duty_g,
    input  logic [W-1:0] duty_b,
    output logic         led_r_n,
    output logic         led_g_n,
    output logic         led_b_n,
    output logic         period_start
);
    localparam logic [W-1:0] LAST = W'(PWM_INTERVAL - 1);

    logic [W-1:0] cnt, shadow_r, shadow_g, shadow_b, ph_g, ph_b;
    logic         wrap;

    assign wrap = (cnt == LAST);

`ifdef PWM_PHASE_STAGGER_EN
    localparam logic [W:0] PER   = (W+1)'(PWM_INTERVAL);
    localparam logic [W:0] OFF_G = (W+1)'(PWM_INTERVAL / 3);
    localparam logic [W:0] OFF_B = (W+1)'(2 * PWM_INTERVAL / 3);

    logic [W:0] sum_g, sum_b;

    // sums stay below 2*PWM_INTERVAL, so one conditional subtract wraps them
    always_comb begin
        sum_g = {1'b0, cnt} + OFF_G;
        sum_b = {1'b0, cnt} + OFF_B;
        ph_g  = (sum_g >= PER) ? W'(sum_g - PER) : W'(sum_g);
        ph_b  = (sum_b >= PER) ? W'(sum_b - PER) : W'(sum_b);
    end
`else
    assign ph_g = cnt;
    assign ph_b = cnt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            shadow_r     <= '0;
            shadow_g     <= '0;
            shadow_b     <= '0;
            led_r_n      <= 1'b1;
            led_g_n      <= 1'b1;
            led_b_n      <= 1'b1;
            period_start <= 1'b0;
        end else if (!en) begin
            // shadows track the inputs so the first enabled period is full length
            cnt          <= '0;
            shadow_r     <= duty_r;
            shadow_g     <= duty_g;
            shadow_b     <= duty_b;
            led_r_n      <= 1'b1;
            led_g_n      <= 1'b1;
            led_b_n      <= 1'b1;
            period_start <= 1'b0;
        end else begin
            cnt          <= wrap ? '0 : cnt + W'(1);
            if (wrap) begin
                shadow_r <= duty_r;
                shadow_g <= duty_g;
                shadow_b <= duty_b;
            end
            led_r_n      <= (cnt >= shadow_r);
            led_g_n      <= (ph_g >= shadow_g);
            led_b_n      <= (ph_b >= shadow_b);
            period_start <= wrap;
        end
    end
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// tb_rgb_pwm_driver: directed bench with a per-cycle expectation queue and period-level counts.
module tb_rgb_pwm_driver;
    localparam int P = 12;
    localparam int W = $clog2(P);
`ifdef PWM_PHASE_STAGGER_EN
    localparam int OG = 4, OB = 8, FG = 8, FB = 4;
`else
    localparam int OG = 0, OB = 0, FG = 0, FB = 0;
`endif

    typedef struct {
        logic r, g, b, ps;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b1, en = 1'b0;
    logic [W-1:0] duty_r = '0, duty_g = '0, duty_b = '0;
    logic led_r_n, led_g_n, led_b_n, period_start;

    int total = 0, bad = 0;
    exp_t sb[$];
    int m_pos = 0, m_r = 0, m_g = 0, m_b = 0;
    int lo_r, lo_g, lo_b, n_ps, ps_at, first_r, first_g, first_b, idx;

    rgb_pwm_driver #(.PWM_INTERVAL(P)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
        .led_r_n(led_r_n), .led_g_n(led_g_n), .led_b_n(led_b_n),
        .period_start(period_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        lo_r = 0; lo_g = 0; lo_b = 0; n_ps = 0; ps_at = -1;
        first_r = -1; first_g = -1; first_b = -1; idx = 0;
    endtask

    // predict the next edge from the inputs being driven, then compare after it
    task automatic cycle();
        exp_t e;
        if (!rst_n) begin
            m_pos = 0; m_r = 0; m_g = 0; m_b = 0;
            e = '{1'b1, 1'b1, 1'b1, 1'b0};
        end else if (!en) begin
            m_pos = 0; m_r = duty_r; m_g = duty_g; m_b = duty_b;
            e = '{1'b1, 1'b1, 1'b1, 1'b0};
        end else begin
            e.r  = !(m_pos < m_r);
            e.g  = !(((m_pos + OG) % P) < m_g);
            e.b  = !(((m_pos + OB) % P) < m_b);
            e.ps = (m_pos == P - 1);
            if (m_pos == P - 1) begin
                m_r = duty_r; m_g = duty_g; m_b = duty_b;
            end
            m_pos = (m_pos + 1) % P;
        end
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb.pop_front();
        check("led_r_n", led_r_n, e.r);
        check("led_g_n", led_g_n, e.g);
        check("led_b_n", led_b_n, e.b);
        check("period_start", period_start, e.ps);
        if (led_r_n === 1'b0) begin lo_r++; if (first_r < 0) first_r = idx; end
        if (led_g_n === 1'b0) begin lo_g++; if (first_g < 0) first_g = idx; end
        if (led_b_n === 1'b0) begin lo_b++; if (first_b < 0) first_b = idx; end
        if (period_start === 1'b1) begin n_ps++; ps_at = idx; end
        idx++;
    endtask

    initial begin
        en = 1'b1; duty_r = 6; duty_g = 6; duty_b = 6;
        #2 rst_n = 1'b0;
        #1;
        check("reset_r", led_r_n, 1'b1);
        check("reset_g", led_g_n, 1'b1);
        check("reset_b", led_b_n, 1'b1);
        check("reset_ps", period_start, 1'b0);
        clr(); repeat (4) cycle();
        check("reset_lo", lo_r + lo_g + lo_b, 0);
        check("reset_nps", n_ps, 0);

        rst_n = 1'b1; duty_r = 3; duty_g = 0; duty_b = 12;
        clr(); repeat (P) cycle();
        check("first_period_lo_r", lo_r, 0);
        clr(); repeat (P) cycle();
        check("steady_lo_r", lo_r, 3);
        check("steady_lo_g", lo_g, 0);
        check("steady_lo_b", lo_b, 12);
        check("steady_nps", n_ps, 1);
        check("steady_ps_at", ps_at, P - 1);

        clr(); repeat (5) cycle();
        duty_r = 9;
        repeat (7) cycle();
        check("midchange_lo_r", lo_r, 3);
        clr(); repeat (11) cycle();
        duty_r = 5;
        cycle();
        check("next_lo_r", lo_r, 9);
        duty_r = 15;
        clr(); repeat (P) cycle();
        check("wrapedge_lo_r", lo_r, 5);
        clr(); repeat (P) cycle();
        check("sat_lo_r", lo_r, 12);
        check("sat_lo_b", lo_b, 12);

        clr(); repeat (4) cycle();
        en = 1'b0; duty_r = 4;
        clr(); repeat (5) cycle();
        check("dis_lo", lo_r + lo_g + lo_b, 0);
        check("dis_nps", n_ps, 0);
        en = 1'b1;
        clr(); repeat (P) cycle();
        check("en_lo_r", lo_r, 4);
        check("en_first_r", first_r, 0);
        check("en_nps", n_ps, 1);
        check("en_ps_at", ps_at, P - 1);

        duty_r = 6; duty_g = 6; duty_b = 6;
        repeat (2) cycle();
        check("pre_rst_r_on", led_r_n, 1'b0);
        rst_n = 1'b0;
        #1;
        check("async_rst_r", led_r_n, 1'b1);
        check("async_rst_b", led_b_n, 1'b1);
        check("async_rst_ps", period_start, 1'b0);
        clr(); repeat (3) cycle();
        check("held_rst_lo", lo_r + lo_g + lo_b, 0);

        rst_n = 1'b1; duty_r = 2; duty_g = 2; duty_b = 2;
        clr(); repeat (P) cycle();
        clr(); repeat (P) cycle();
        check("phase_lo_r", lo_r, 2);
        check("phase_lo_g", lo_g, 2);
        check("phase_lo_b", lo_b, 2);
        check("phase_first_r", first_r, 0);
        check("phase_first_g", first_g, FG);
        check("phase_first_b", first_b, FB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
